// File: rtl/ycrcb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ycrcb_pkg: shared coefficients, internal width and clamp helpers
// Rev 1.0
// ------------------------------------------------------------------
package ycrcb_pkg;

    localparam int c_FRAC   = 6;
    localparam int c_K_R_CB = 73;
    localparam int c_K_G_CR = 25;
    localparam int c_K_G_CB = 37;
    localparam int c_K_B_CR = 130;

    // Three guard bits keep Y plus two chroma terms free of overflow.
    function automatic int int_w(input int in_w);
        return in_w + 3;
    endfunction

    function automatic logic [31:0] clamp_u(input logic signed [31:0] value, input int out_w);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< out_w) - 32'sd1;
        if (value < 32'sd0)
            return '0;
        else if (value > max_v)
            return $unsigned(max_v);
        else
            return $unsigned(value);
    endfunction

    function automatic logic is_sat(input logic signed [31:0] value, input int out_w);
        logic signed [31:0] max_v;
        max_v = (32'sd1 <<< out_w) - 32'sd1;
        return (value < 32'sd0) || (value > max_v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_mul_tz.sv
`default_nettype none
// ------------------------------------------------------------------
// coef_mul_tz: signed term sign(c)*((K*|c|) >> FRAC), truncating toward zero
// Rev 1.0
// ------------------------------------------------------------------
module coef_mul_tz
    import ycrcb_pkg::*;
#(
    parameter int IN_W = 10,
    parameter int K    = 73,
    parameter int FRAC = 6
) (
    input  logic signed [IN_W-1:0]        i_c,
    output logic signed [int_w(IN_W)-1:0] o_term
);

    localparam int K_W    = $clog2(K + 1);
    localparam int PROD_W = IN_W + K_W;
    localparam int INT_W  = int_w(IN_W);

    logic                    w_neg;
    logic [IN_W-1:0]         w_mag;
    logic [PROD_W-1:0]       w_prod;
    logic signed [INT_W-1:0] w_mag_t;

    // Most negative input negates to itself, which reads correctly as unsigned 2^(IN_W-1).
    assign w_neg   = i_c[IN_W-1];
    assign w_mag   = w_neg ? $unsigned(-i_c) : $unsigned(i_c);
    assign w_prod  = PROD_W'(w_mag) * PROD_W'(K);
    assign w_mag_t = $signed(INT_W'(w_prod >> FRAC));
    assign o_term  = w_neg ? -w_mag_t : w_mag_t;

endmodule
`default_nettype wire

// File: rtl/ycrcb2rgb_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// ycrcb2rgb_pipe: 3-stage YCrCb->RGB with global stall, clamping and sat counter
// Rev 1.0
// ------------------------------------------------------------------
module ycrcb2rgb_pipe
    import ycrcb_pkg::*;
#(
    parameter int IN_W   = 10,
    parameter int OUT_W  = 8,
    parameter int FRAC   = c_FRAC,
    parameter int K_R_CB = c_K_R_CB,
    parameter int K_G_CR = c_K_G_CR,
    parameter int K_G_CB = c_K_G_CB,
    parameter int K_B_CR = c_K_B_CR,
    parameter int USER_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        y,
    input  logic signed [IN_W-1:0] cr,
    input  logic signed [IN_W-1:0] cb,
    input  logic [USER_W-1:0]      in_user,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       r,
    output logic [OUT_W-1:0]       g,
    output logic [OUT_W-1:0]       b,
    output logic [USER_W-1:0]      out_user,
    output logic                   out_sat,
    input  logic                   sat_clear,
    output logic [CNT_W-1:0]       sat_count
);

    localparam int INT_W = int_w(IN_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic                    w_adv;
    logic signed [INT_W-1:0] w_t_rcb, w_t_gcr, w_t_gcb, w_t_bcr;

    logic                    r_s1_valid;
    logic signed [INT_W-1:0] r_s1_y, r_s1_t_rcb, r_s1_t_gcr, r_s1_t_gcb, r_s1_t_bcr;
    logic [USER_W-1:0]       r_s1_user;

    logic                    r_s2_valid;
    logic signed [INT_W-1:0] r_s2_r, r_s2_g, r_s2_b;
    logic [USER_W-1:0]       r_s2_user;

    logic                    r_s3_valid;
    logic [OUT_W-1:0]        r_s3_r, r_s3_g, r_s3_b;
    logic [USER_W-1:0]       r_s3_user;
    logic                    r_s3_sat;
    logic [CNT_W-1:0]        r_sat_count;

    coef_mul_tz #(.IN_W(IN_W), .K(K_R_CB), .FRAC(FRAC)) u_mul_rcb (.i_c(cb), .o_term(w_t_rcb));
    coef_mul_tz #(.IN_W(IN_W), .K(K_G_CR), .FRAC(FRAC)) u_mul_gcr (.i_c(cr), .o_term(w_t_gcr));
    coef_mul_tz #(.IN_W(IN_W), .K(K_G_CB), .FRAC(FRAC)) u_mul_gcb (.i_c(cb), .o_term(w_t_gcb));
    coef_mul_tz #(.IN_W(IN_W), .K(K_B_CR), .FRAC(FRAC)) u_mul_bcr (.i_c(cr), .o_term(w_t_bcr));

    // Whole pipe moves together; bubbles shift too so spacing is preserved.
    assign w_adv    = !r_s3_valid || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_y     <= '0;
            r_s1_t_rcb <= '0;
            r_s1_t_gcr <= '0;
            r_s1_t_gcb <= '0;
            r_s1_t_bcr <= '0;
            r_s1_user  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_g     <= '0;
            r_s2_b     <= '0;
            r_s2_user  <= '0;
            r_s3_valid <= 1'b0;
            r_s3_r     <= '0;
            r_s3_g     <= '0;
            r_s3_b     <= '0;
            r_s3_user  <= '0;
            r_s3_sat   <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_y     <= $signed(INT_W'(y));
            r_s1_t_rcb <= w_t_rcb;
            r_s1_t_gcr <= w_t_gcr;
            r_s1_t_gcb <= w_t_gcb;
            r_s1_t_bcr <= w_t_bcr;
            r_s1_user  <= in_user;

            r_s2_valid <= r_s1_valid;
            r_s2_r     <= r_s1_y + r_s1_t_rcb;
            r_s2_g     <= r_s1_y - r_s1_t_gcr - r_s1_t_gcb;
            r_s2_b     <= r_s1_y + r_s1_t_bcr;
            r_s2_user  <= r_s1_user;

            r_s3_valid <= r_s2_valid;
            r_s3_r     <= OUT_W'(clamp_u(32'(r_s2_r), OUT_W));
            r_s3_g     <= OUT_W'(clamp_u(32'(r_s2_g), OUT_W));
            r_s3_b     <= OUT_W'(clamp_u(32'(r_s2_b), OUT_W));
            r_s3_sat   <= is_sat(32'(r_s2_r), OUT_W) || is_sat(32'(r_s2_g), OUT_W)
                       || is_sat(32'(r_s2_b), OUT_W);
            r_s3_user  <= r_s2_user;
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_sat_count <= '0;
        else if (sat_clear)
            r_sat_count <= '0;
        else if (r_s3_valid && out_ready && r_s3_sat && (r_sat_count != c_CNT_MAX))
            r_sat_count <= r_sat_count + CNT_W'(1);
    end

    assign out_valid = r_s3_valid;
    assign r         = r_s3_r;
    assign g         = r_s3_g;
    assign b         = r_s3_b;
    assign out_user  = r_s3_user;
    assign out_sat   = r_s3_sat;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_ycrcb2rgb_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ycrcb2rgb_pipe: directed self-checking bench (CNT_W=3 build)
// Rev 1.0
// ------------------------------------------------------------------
module tb_ycrcb2rgb_pipe;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [9:0]        y = '0;
    logic signed [9:0] cr = '0;
    logic signed [9:0] cb = '0;
    logic [1:0]        in_user = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        r, g, b;
    logic [1:0]        out_user;
    logic              out_sat;
    logic              sat_clear = 1'b0;
    logic [2:0]        sat_count;

    int total = 0;
    int bad   = 0;

    ycrcb2rgb_pipe #(.CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .cr(cr), .cb(cb), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .g(g), .b(b), .out_user(out_user), .out_sat(out_sat),
        .sat_clear(sat_clear), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one pixel into an empty pipe and check it after exactly three edges.
    task automatic send(input string tag, input int yy, input int vcr, input int vcb, input int uu,
                        input int er, input int eg, input int eb, input int es);
        y = 10'(yy); cr = 10'(vcr); cb = 10'(vcb); in_user = 2'(uu);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        tick();
        chk({tag, "_lat2"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_r"}, r, er);
        chk({tag, "_g"}, g, eg);
        chk({tag, "_b"}, b, eb);
        chk({tag, "_sat"}, out_sat, es);
        chk({tag, "_user"}, out_user, uu);
        tick();
    endtask

    int  yv[8] = '{11, 22, 33, 44, 55, 66, 77, 88};
    bit  rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit  gp[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int  sent, got;
    bit  prev_stall;
    logic [7:0] held_r;
    logic [1:0] held_u;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_rgb", {8'h0, r, g, b}, 0);
        chk("rst_user", out_user, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_count", sat_count, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        tick();

        // Basic conversion and symmetric truncation
        send("grey", 100, 0, 0, 1, 100, 100, 100, 0);
        send("cb_pos", 100, 0, 64, 2, 173, 63, 100, 0);
        send("cb_neg", 100, 0, -64, 3, 27, 137, 100, 0);
        send("odd_tz", 128, -3, 5, 0, 133, 127, 122, 0);
        chk("count0", sat_count, 0);

        // Clamping and saturation counting
        send("clamp_hi", 250, 0, 100, 1, 255, 193, 250, 1);
        chk("count1", sat_count, 1);
        send("clamp_lo", 10, 100, 0, 2, 10, 0, 213, 1);
        chk("count2", sat_count, 2);
        send("extreme", 0, -512, -512, 3, 0, 255, 0, 1);
        chk("count3", sat_count, 3);

        // Streaming with stalls and input gaps
        sent = 0; got = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            out_ready = rp[cyc % 4];
            in_valid  = (sent < 8) && gp[cyc % 5];
            if (sent < 8) begin
                y = 10'(yv[sent]); cr = '0; cb = '0; in_user = 2'(sent);
            end
            @(negedge clk);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_r", r, held_r);
                chk("hold_user", out_user, held_u);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                held_r = r; held_u = out_user; prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("stream_r", r, yv[got]);
                chk("stream_b", b, yv[got]);
                chk("stream_user", out_user, got % 4);
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        chk("stream_count", got, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_dup", out_valid, 0);
        end
        chk("count_after_stream", sat_count, 3);

        // Counter saturates at 7
        y = 10'd250; cr = '0; cb = 10'sd100; in_user = '0;
        in_valid = 1'b1;
        repeat (6) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("count_hold7", sat_count, 7);

        // Clear wins over a simultaneous saturating handshake
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("clr_pix_valid", out_valid, 1);
        chk("clr_pix_sat", out_sat, 1);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("count_clear", sat_count, 0);
        send("after_clr", 250, 0, 100, 0, 255, 193, 250, 1);
        chk("count_after_clr", sat_count, 1);

        // Reset with three pixels in flight
        out_ready = 1'b1;
        cr = '0; cb = '0;
        for (int i = 0; i < 3; i++) begin
            y = 10'(30 + 10 * i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_r", r, 0);
        chk("midrst_count", sat_count, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale", out_valid, 0);
        end
        send("post_rst", 60, 0, 0, 2, 60, 60, 60, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
